// File: rtl/demux_1_n_stream.sv
// Registered 1xN stream demultiplexer.
// One valid/ready producer feeds N consumers. Each consumer has its own
// one-entry output register. The target channel comes either from in_sel
// (MODE=0) or from an internal round-robin pointer (MODE=1). In MODE=0 a
// selector >= N (only possible when N is not a power of two) consumes the beat,
// changes no output register and raises err for one cycle.
module demux_1_n_stream #(
    parameter int  N    = 8,
    parameter int  DW   = 8,
    parameter int  MODE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [W-1:0]    in_sel,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*DW-1:0] out_data,
    output logic            err,
    output logic [W-1:0]    rr_ptr
);

    // N widened by one bit so that a selector of all ones can be range-checked.
    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [W-1:0] target;
    logic         in_range;
    logic         slot_free;
    logic         accept;

    logic         err_q, err_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    // Select the target channel and decide whether the input can be taken now.
    always_comb begin
        if (MODE == 1) begin
            target = rr_ptr_q;
        end else begin
            target = in_sel;
        end
        in_range  = ({1'b0, target} < N_EXT);
        // A slot is free when empty, or when its consumer drains it this cycle,
        // which allows a new beat to pass straight in without a bubble.
        slot_free = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (target == W'(k)) begin
                slot_free = ~out_valid[k] | out_ready[k];
            end
        end
        // Out-of-range beats are always consumed so the producer never hangs.
        in_ready = ~in_range | slot_free;
        // in_valid gates everything, so an unknown in_sel while idle is harmless.
        accept   = in_valid & in_ready;
    end

    // Error pulse and round-robin pointer next state.
    always_comb begin
        err_d    = accept & ~in_range;
        rr_ptr_d = rr_ptr_q;
        if ((MODE == 1) && accept) begin
            if (rr_ptr_q == W'(N - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = rr_ptr_q + W'(1);
            end
        end
    end

    // Error flag and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            err_q    <= err_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign err    = err_q;
    assign rr_ptr = rr_ptr_q;

    // One independent output register per channel; a stalled channel only
    // ever blocks beats that target it.
    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_chan
        logic          load;
        logic          valid_q, valid_d;
        logic [DW-1:0] data_q, data_d;

        assign load = accept & in_range & (target == W'(gi));

        // Load wins over drain so a simultaneous drain+load keeps valid high.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (load) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (out_ready[gi]) begin
                valid_d = 1'b0;
            end
        end

        // Channel register; data is held stable while waiting on the consumer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid[gi]           = valid_q;
        assign out_data[gi*DW +: DW]   = data_q;
    end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Testbench for demux_1_n_stream: three instances cover the addressed N=8,
// round-robin N=4 and addressed non-power-of-two N=5 configurations.
// A behavioural model of the per-channel slots tracks the expected state.
module tb_demux_1_n_stream;

    localparam int NN [3] = '{8, 4, 5};
    localparam int MM [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Generic per-instance stimulus
    logic       in_valid  [3];
    logic [7:0] in_data   [3];
    logic [2:0] in_sel    [3];
    logic [7:0] out_ready [3];

    // Generic per-instance observations
    logic        in_ready_g [3];
    logic [7:0]  ov_g       [3];
    logic [63:0] od_g       [3];
    logic        err_g      [3];
    logic [2:0]  rr_g       [3];

    // Instance-specific outputs
    logic        a_rdy, b_rdy, c_rdy;
    logic [7:0]  a_ov;
    logic [3:0]  b_ov;
    logic [4:0]  c_ov;
    logic [63:0] a_od;
    logic [31:0] b_od;
    logic [39:0] c_od;
    logic        a_err, b_err, c_err;
    logic [2:0]  a_rr;
    logic [1:0]  b_rr;
    logic [2:0]  c_rr;

    demux_1_n_stream #(.N(8), .DW(8), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(a_rdy), .in_data(in_data[0]),
        .in_sel(in_sel[0]), .out_valid(a_ov), .out_ready(out_ready[0]),
        .out_data(a_od), .err(a_err), .rr_ptr(a_rr)
    );

    demux_1_n_stream #(.N(4), .DW(8), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(b_rdy), .in_data(in_data[1]),
        .in_sel(in_sel[1][1:0]), .out_valid(b_ov), .out_ready(out_ready[1][3:0]),
        .out_data(b_od), .err(b_err), .rr_ptr(b_rr)
    );

    demux_1_n_stream #(.N(5), .DW(8), .MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(c_rdy), .in_data(in_data[2]),
        .in_sel(in_sel[2]), .out_valid(c_ov), .out_ready(out_ready[2][4:0]),
        .out_data(c_od), .err(c_err), .rr_ptr(c_rr)
    );

    always_comb begin
        in_ready_g[0] = a_rdy;
        in_ready_g[1] = b_rdy;
        in_ready_g[2] = c_rdy;
        ov_g[0]       = a_ov;
        ov_g[1]       = {4'b0, b_ov};
        ov_g[2]       = {3'b0, c_ov};
        od_g[0]       = a_od;
        od_g[1]       = {32'b0, b_od};
        od_g[2]       = {24'b0, c_od};
        err_g[0]      = a_err;
        err_g[1]      = b_err;
        err_g[2]      = c_err;
        rr_g[0]       = a_rr;
        rr_g[1]       = {1'b0, b_rr};
        rr_g[2]       = c_rr;
    end

    // ---------------- behavioural model ----------------
    bit         mv   [3][8];
    logic [7:0] md   [3][8];
    int         mrr  [3];
    bit         merr [3];
    bit         mrdy [3];
    bit         macc [3];
    logic       snap_rdy [3];

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) begin
                mv[d][k] = 1'b0;
                md[d][k] = 8'h00;
            end
            mrr[d]  = 0;
            merr[d] = 1'b0;
        end
    endtask

    function automatic int mtarget(input int d);
        return (MM[d] == 1) ? mrr[d] : int'(in_sel[d]);
    endfunction

    function automatic bit model_ready(input int d);
        int t;
        t = mtarget(d);
        if (t >= NN[d]) return 1'b1;
        return !mv[d][t] || (out_ready[d][t] == 1'b1);
    endfunction

    function automatic logic [7:0] exp_ov(input int d);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < NN[d]; k++) r[k] = mv[d][k];
        return r;
    endfunction

    function automatic logic [63:0] exp_od(input int d);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < NN[d]; k++) r[k*8 +: 8] = md[d][k];
        return r;
    endfunction

    // Advance one clock: capture handshake before the edge, update the model at the edge.
    task automatic tick();
        bit         nv   [3][8];
        logic [7:0] nd   [3][8];
        int         nrr  [3];
        bit         nerr [3];
        int         t;
        #1;
        for (int d = 0; d < 3; d++) begin
            snap_rdy[d] = in_ready_g[d];
            mrdy[d]     = model_ready(d);
            macc[d]     = (in_valid[d] == 1'b1) && mrdy[d] && (rst_n == 1'b1);
            nv[d]       = mv[d];
            nd[d]       = md[d];
            nrr[d]      = mrr[d];
            nerr[d]     = 1'b0;
            for (int k = 0; k < NN[d]; k++) begin
                if (mv[d][k] && out_ready[d][k] == 1'b1) nv[d][k] = 1'b0;
            end
            if (macc[d]) begin
                t = mtarget(d);
                if (t < NN[d]) begin
                    nv[d][t] = 1'b1;
                    nd[d][t] = in_data[d];
                end else begin
                    nerr[d] = 1'b1;
                end
                if (MM[d] == 1) nrr[d] = (mrr[d] + 1) % NN[d];
            end
        end
        @(posedge clk);
        mv   = nv;
        md   = nd;
        mrr  = nrr;
        merr = nerr;
        if (!rst_n) model_clear();
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 8'hFF;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({ov_g[d], od_g[d], err_g[d], rr_g[d]} !== '0) begin
                failures++;
                $display("FAIL reset_init[%0d]: got ov=%h od=%h err=%b rr=%0d, expected all zero",
                         d, ov_g[d], od_g[d], err_g[d], rr_g[d]);
            end
        end
        // A beat offered during reset must not be taken.
        in_valid[0] = 1'b1; in_sel[0] = 3'd2; in_data[0] = 8'h5A;
        tick();
        checks++;
        if (ov_g[0] !== 8'h00) begin
            failures++;
            $display("FAIL reset_no_accept: got ov=%h expected 00", ov_g[0]);
        end
        rst_n = 1'b1;
        // Fill every channel of the addressed instance, and some of the round-robin one.
        out_ready[0] = 8'h00;
        out_ready[1] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            in_valid[0] = 1'b1; in_sel[0] = 3'(i); in_data[0] = 8'h10 + 8'(i);
            in_valid[1] = (i < 3); in_data[1] = 8'h40 + 8'(i);
            tick();
        end
        idle_all();
        out_ready[0] = 8'h00;
        out_ready[1] = 8'h00;
        checks++;
        if (ov_g[0] !== 8'hFF || rr_g[1] !== 3'd3) begin
            failures++;
            $display("FAIL reset_fill: got ov=%h rr=%0d expected ov=ff rr=3", ov_g[0], rr_g[1]);
        end
        // Assert reset between edges and look before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (ov_g[0] !== 8'h00 || od_g[0] !== 64'h0 || ov_g[1] !== 8'h00 || rr_g[1] !== 3'd0) begin
            failures++;
            $display("FAIL reset_async: got ov0=%h od0=%h ov1=%h rr1=%0d expected all zero",
                     ov_g[0], od_g[0], ov_g[1], rr_g[1]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_all();
    endtask

    task automatic test_addressed();
        for (int i = 0; i < 8; i++) begin
            in_valid[0] = 1'b1; in_sel[0] = 3'(i); in_data[0] = 8'hA0 + 8'(i);
            tick();
            checks++;
            if (ov_g[0] !== (8'h01 << i) || od_g[0][i*8 +: 8] !== (8'hA0 + 8'(i))) begin
                failures++;
                $display("FAIL addressed[%0d]: got ov=%h data=%h expected ov=%h data=%h",
                         i, ov_g[0], od_g[0][i*8 +: 8], 8'h01 << i, 8'hA0 + 8'(i));
            end
        end
        in_valid[0] = 1'b0;
        tick();
        checks++;
        if (ov_g[0] !== 8'h00) begin
            failures++;
            $display("FAIL addressed_drain: got ov=%h expected 00", ov_g[0]);
        end
    endtask

    task automatic test_backpressure();
        out_ready[0] = 8'hF7;
        in_valid[0] = 1'b1; in_sel[0] = 3'd3; in_data[0] = 8'h31;
        tick();
        in_data[0] = 8'h32;
        tick();
        checks++;
        if (snap_rdy[0] !== 1'b0 || ov_g[0][3] !== 1'b1 || od_g[0][31:24] !== 8'h31) begin
            failures++;
            $display("FAIL bp_hold: got rdy=%b v3=%b d3=%h expected rdy=0 v3=1 d3=31",
                     snap_rdy[0], ov_g[0][3], od_g[0][31:24]);
        end
        in_sel[0] = 3'd5; in_data[0] = 8'h55;
        tick();
        checks++;
        if (snap_rdy[0] !== 1'b1 || ov_g[0] !== 8'h28 || od_g[0][47:40] !== 8'h55) begin
            failures++;
            $display("FAIL bp_other: got rdy=%b ov=%h d5=%h expected rdy=1 ov=28 d5=55",
                     snap_rdy[0], ov_g[0], od_g[0][47:40]);
        end
        out_ready[0] = 8'hFF;
        in_sel[0] = 3'd3; in_data[0] = 8'h32;
        tick();
        checks++;
        if (snap_rdy[0] !== 1'b1 || ov_g[0] !== 8'h08 || od_g[0][31:24] !== 8'h32) begin
            failures++;
            $display("FAIL bp_release: got rdy=%b ov=%h d3=%h expected rdy=1 ov=08 d3=32",
                     snap_rdy[0], ov_g[0], od_g[0][31:24]);
        end
        in_valid[0] = 1'b0;
        tick();
        checks++;
        if (ov_g[0] !== 8'h00) begin
            failures++;
            $display("FAIL bp_no_dup: got ov=%h expected 00", ov_g[0]);
        end
    endtask

    task automatic test_passthrough();
        out_ready[0] = 8'hFB;
        in_valid[0] = 1'b1; in_sel[0] = 3'd2; in_data[0] = 8'h21;
        tick();
        out_ready[0] = 8'hFF;
        in_data[0] = 8'h22;
        tick();
        checks++;
        if (snap_rdy[0] !== 1'b1 || ov_g[0] !== 8'h04 || od_g[0][23:16] !== 8'h22) begin
            failures++;
            $display("FAIL passthrough: got rdy=%b ov=%h d2=%h expected rdy=1 ov=04 d2=22",
                     snap_rdy[0], ov_g[0], od_g[0][23:16]);
        end
        in_valid[0] = 1'b0;
        tick();
        checks++;
        if (ov_g[0] !== 8'h00) begin
            failures++;
            $display("FAIL passthrough_drain: got ov=%h expected 00", ov_g[0]);
        end
    endtask

    task automatic test_round_robin();
        int got  = 0;
        int cyc  = 0;
        int base = mrr[1];
        int ch;
        while (got < 6 && cyc < 200) begin
            in_valid[1]  = ($urandom_range(0, 2) != 0);
            in_data[1]   = 8'h60 + 8'(got);
            in_sel[1]    = 3'($urandom);
            out_ready[1] = {4'b0, 4'($urandom)};
            tick();
            cyc++;
            checks++;
            if (snap_rdy[1] !== mrdy[1]) begin
                failures++;
                $display("FAIL rr_ready: got %b expected %b", snap_rdy[1], mrdy[1]);
            end
            if (macc[1]) begin
                ch = (base + got) % 4;
                checks++;
                if (ov_g[1][ch] !== 1'b1 || od_g[1][ch*8 +: 8] !== (8'h60 + 8'(got))) begin
                    failures++;
                    $display("FAIL rr_route[%0d]: got v=%b d=%h on ch%0d expected v=1 d=%h",
                             got, ov_g[1][ch], od_g[1][ch*8 +: 8], ch, 8'h60 + 8'(got));
                end
                got++;
            end
            checks++;
            if (rr_g[1] !== 3'((base + got) % 4)) begin
                failures++;
                $display("FAIL rr_ptr: got %0d expected %0d", rr_g[1], (base + got) % 4);
            end
        end
        checks++;
        if (got != 6) begin
            failures++;
            $display("FAIL rr_budget: got %0d beats expected 6", got);
        end
        idle_all();
        tick();
    endtask

    task automatic test_out_of_range();
        out_ready[2] = 8'h00;
        in_valid[2] = 1'b1; in_sel[2] = 3'd1; in_data[2] = 8'h11;
        tick();
        for (int s = 5; s < 8; s++) begin
            in_valid[2] = 1'b1; in_sel[2] = 3'(s); in_data[2] = 8'hE0 + 8'(s);
            tick();
            checks++;
            if (snap_rdy[2] !== 1'b1 || err_g[2] !== 1'b1 || ov_g[2] !== 8'h02 ||
                od_g[2] !== 64'h0000_0000_0000_1100) begin
                failures++;
                $display("FAIL oor_sel%0d: got rdy=%b err=%b ov=%h od=%h expected rdy=1 err=1 ov=02 od=1100",
                         s, snap_rdy[2], err_g[2], ov_g[2], od_g[2]);
            end
            in_valid[2] = 1'b0;
            tick();
            checks++;
            if (err_g[2] !== 1'b0) begin
                failures++;
                $display("FAIL oor_pulse%0d: got err=%b expected 0", s, err_g[2]);
            end
        end
        idle_all();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                in_valid[d]  = ($urandom_range(0, 3) != 0);
                in_sel[d]    = 3'($urandom);
                in_data[d]   = 8'($urandom);
                out_ready[d] = 8'($urandom);
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (snap_rdy[d] !== mrdy[d]) begin
                    failures++;
                    $display("FAIL rand_ready[%0d] c%0d: got %b expected %b", d, c, snap_rdy[d], mrdy[d]);
                end
                checks++;
                if (ov_g[d] !== exp_ov(d)) begin
                    failures++;
                    $display("FAIL rand_valid[%0d] c%0d: got %h expected %h", d, c, ov_g[d], exp_ov(d));
                end
                checks++;
                if (od_g[d] !== exp_od(d)) begin
                    failures++;
                    $display("FAIL rand_data[%0d] c%0d: got %h expected %h", d, c, od_g[d], exp_od(d));
                end
                checks++;
                if (err_g[d] !== merr[d]) begin
                    failures++;
                    $display("FAIL rand_err[%0d] c%0d: got %b expected %b", d, c, err_g[d], merr[d]);
                end
                checks++;
                if (rr_g[d] !== 3'(mrr[d])) begin
                    failures++;
                    $display("FAIL rand_rr[%0d] c%0d: got %0d expected %0d", d, c, rr_g[d], mrr[d]);
                end
            end
        end
        idle_all();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 8'h00;
            in_sel[d]    = 3'd0;
            out_ready[d] = 8'hFF;
        end
        test_reset();
        test_addressed();
        test_backpressure();
        test_passthrough();
        test_round_robin();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
